// File: rtl/cdr_dig_loop.sv
// Digital bang-bang CDR loop: Alexander phase detector with majority vote, lock FSM and PI code accumulator.
// Optional macro CDR_FREQ_PATH_EN enables the saturating integral (frequency) path for a 2nd-order loop.
module cdr_dig_loop #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned PI_CODE_W  = 7,
    parameter int unsigned FRAC_W     = 8,
    parameter int unsigned INT_W      = 12,
    parameter int unsigned KP_ACQ     = 6,
    parameter int unsigned KP_TRK     = 4,
    parameter int unsigned LOCK_WIN   = 64,
    parameter int unsigned LOCK_THR   = 4,
    parameter int unsigned LOCK_HITS  = 4,
    parameter int unsigned UNLOCK_THR = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 smp_valid,
    input  logic [DATA_W-1:0]    data_smp,
    input  logic [DATA_W-1:0]    edge_smp,
    output logic [PI_CODE_W-1:0] pi_code,
    output logic [DATA_W-1:0]    dout,
    output logic                 dout_valid,
    output logic                 lock,
    output logic [INT_W-1:0]     int_acc
);
    localparam int unsigned PH_W  = PI_CODE_W + FRAC_W;
    localparam int unsigned WC_W  = $clog2(LOCK_WIN);
    localparam int unsigned NET_W = WC_W + 2;
    localparam int unsigned HIT_W = $clog2(LOCK_HITS + 1);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_e;

    state_e                 state_q, state_d;
    logic [PH_W-1:0]        phase_acc_q, phase_acc_d;
    logic [PI_CODE_W-1:0]   pi_code_q, pi_code_d;
    logic [DATA_W-1:0]      dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   lock_q, lock_d;
    logic                   prev_bit_q, prev_bit_d;
    logic [WC_W-1:0]        win_q, win_d;
    logic [NET_W-1:0]       net_q, net_d;
    logic [HIT_W-1:0]       hits_q, hits_d;

    logic                   upd;
    logic [DATA_W-1:0]      prev_vec;
    logic [CNT_W-1:0]       n_early, n_late;
    logic [1:0]             vote;
    logic [PH_W-1:0]        vote_ext, p_term, i_term;
    logic [NET_W-1:0]       net_nx, net_abs;

`ifdef CDR_FREQ_PATH_EN
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-2){1'b0}}, 1'b1};
    logic [INT_W-1:0] int_acc_q, int_acc_d;
`endif

    assign upd = en & smp_valid;

    // Alexander detector: each transition is either early or late depending on the edge sample
    always_comb begin
        prev_vec = {data_smp[DATA_W-2:0], prev_bit_q};
        n_early  = '0;
        n_late   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (prev_vec[i] ^ data_smp[i]) begin
                if (edge_smp[i] == prev_vec[i]) n_early = n_early + CNT_W'(1);
                else                            n_late  = n_late + CNT_W'(1);
            end
        end
        if (n_early > n_late)      vote = 2'b01;
        else if (n_early < n_late) vote = 2'b11;
        else                       vote = 2'b00;
    end

    always_comb begin
        vote_ext = {{(PH_W-2){vote[1]}}, vote};
        p_term   = (state_q == LOCKED) ? (vote_ext << KP_TRK) : (vote_ext << KP_ACQ);
`ifdef CDR_FREQ_PATH_EN
        i_term   = {{(PH_W-INT_W){int_acc_q[INT_W-1]}}, int_acc_q};
`else
        i_term   = '0;
`endif
        net_nx   = net_q + {{(NET_W-2){vote[1]}}, vote};
        net_abs  = net_nx[NET_W-1] ? (~net_nx + NET_W'(1)) : net_nx;
    end

    always_comb begin
        state_d      = state_q;
        phase_acc_d  = phase_acc_q;
        pi_code_d    = pi_code_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        lock_d       = lock_q;
        prev_bit_d   = prev_bit_q;
        win_d        = win_q;
        net_d        = net_q;
        hits_d       = hits_q;
`ifdef CDR_FREQ_PATH_EN
        int_acc_d    = int_acc_q;
`endif
        if (!en) begin
            state_d = IDLE;
            lock_d  = 1'b0;
            win_d   = '0;
            net_d   = '0;
            hits_d  = '0;
        end else begin
            if (upd) begin
                phase_acc_d  = phase_acc_q + p_term + i_term;
                pi_code_d    = phase_acc_d[PH_W-1 -: PI_CODE_W];
                prev_bit_d   = data_smp[DATA_W-1];
                dout_d       = data_smp;
                dout_valid_d = 1'b1;
`ifdef CDR_FREQ_PATH_EN
                if (vote == 2'b01 && int_acc_q != INT_MAX)
                    int_acc_d = int_acc_q + INT_W'(1);
                else if (vote == 2'b11 && int_acc_q != INT_MIN)
                    int_acc_d = int_acc_q - INT_W'(1);
`endif
            end
            case (state_q)
                IDLE: state_d = ACQ;
                ACQ, LOCKED: begin
                    if (upd) begin
                        if (win_q == WC_W'(LOCK_WIN - 1)) begin
                            win_d = '0;
                            net_d = '0;
                            if (state_q == ACQ) begin
                                if (net_abs <= NET_W'(LOCK_THR)) begin
                                    if (hits_q == HIT_W'(LOCK_HITS - 1)) begin
                                        state_d = LOCKED;
                                        lock_d  = 1'b1;
                                        hits_d  = '0;
                                    end else begin
                                        hits_d = hits_q + HIT_W'(1);
                                    end
                                end else begin
                                    hits_d = '0;
                                end
                            end else if (net_abs > NET_W'(UNLOCK_THR)) begin
                                state_d = ACQ;
                                lock_d  = 1'b0;
                                hits_d  = '0;
                            end
                        end else begin
                            win_d = win_q + WC_W'(1);
                            net_d = net_nx;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_acc_q  <= '0;
            pi_code_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            lock_q       <= 1'b0;
            prev_bit_q   <= 1'b0;
            win_q        <= '0;
            net_q        <= '0;
            hits_q       <= '0;
`ifdef CDR_FREQ_PATH_EN
            int_acc_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phase_acc_q  <= phase_acc_d;
            pi_code_q    <= pi_code_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            lock_q       <= lock_d;
            prev_bit_q   <= prev_bit_d;
            win_q        <= win_d;
            net_q        <= net_d;
            hits_q       <= hits_d;
`ifdef CDR_FREQ_PATH_EN
            int_acc_q    <= int_acc_d;
`endif
        end
    end

    assign pi_code    = pi_code_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign lock       = lock_q;
`ifdef CDR_FREQ_PATH_EN
    assign int_acc    = int_acc_q;
`else
    assign int_acc    = '0;
`endif

endmodule

// File: tb/tb_cdr_dig_loop.sv
// Scoreboard bench for cdr_dig_loop: randomized and directed words against a bit-stream reference model.
module tb_cdr_dig_loop;
    localparam int KP_ACQ = 6, KP_TRK = 4, LOCK_WIN = 64, LOCK_THR = 4, LOCK_HITS = 4, UNLOCK_THR = 16;
    localparam int PH_MOD = 1 << 15;
    localparam int INT_LIM = 2047;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       smp_valid = 1'b0;
    logic [3:0] data_smp = '0;
    logic [3:0] edge_smp = '0;
    logic [6:0] pi_code;
    logic [3:0] dout;
    logic       dout_valid;
    logic       lock;
    logic [11:0] int_acc;

    cdr_dig_loop dut (
        .clk(clk), .rst_n(rst_n), .en(en), .smp_valid(smp_valid),
        .data_smp(data_smp), .edge_smp(edge_smp), .pi_code(pi_code),
        .dout(dout), .dout_valid(dout_valid), .lock(lock), .int_acc(int_acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pi; int lk; int ia; int dv; int dq;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state, in plain integers
    int m_phase, m_int, m_prev, m_mode, m_cnt, m_net, m_hits, m_dv, m_dout;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_int = 0; m_prev = 0; m_mode = 0;
        m_cnt = 0; m_net = 0; m_hits = 0; m_dv = 0; m_dout = 0;
    endtask

    // Walk the serial bit stream: each transition is early if the edge matches the old bit, else late
    function automatic int vote_of(input logic [3:0] d, input logic [3:0] e, input int prev);
        int early = 0, late = 0, dp = prev;
        for (int i = 0; i < 4; i++) begin
            if (int'(d[i]) != dp) begin
                if (int'(e[i]) == dp) early++;
                else late++;
            end
            dp = int'(d[i]);
        end
        return (early > late) ? 1 : (early < late) ? -1 : 0;
    endfunction

    task automatic model_step(input logic en_i, input logic v_i, input logic [3:0] d, input logic [3:0] e);
        int vote, kp, p, a;
        exp_t x;
        if (!en_i) begin
            m_mode = 0; m_cnt = 0; m_net = 0; m_hits = 0; m_dv = 0;
        end else begin
            m_dv = int'(v_i);
            if (v_i) begin
                vote = vote_of(d, e, m_prev);
                kp = (m_mode == 2) ? KP_TRK : KP_ACQ;
                p = m_phase + vote * (1 << kp) + m_int;
                m_phase = ((p % PH_MOD) + PH_MOD) % PH_MOD;
`ifdef CDR_FREQ_PATH_EN
                m_int = m_int + vote;
                if (m_int > INT_LIM) m_int = INT_LIM;
                if (m_int < -INT_LIM) m_int = -INT_LIM;
`endif
                m_prev = int'(d[3]);
                m_dout = int'(d);
                if (m_mode != 0) begin
                    m_net += vote;
                    m_cnt++;
                    if (m_cnt == LOCK_WIN) begin
                        a = (m_net < 0) ? -m_net : m_net;
                        if (m_mode == 1) begin
                            m_hits = (a <= LOCK_THR) ? m_hits + 1 : 0;
                            if (m_hits == LOCK_HITS) begin m_mode = 2; m_hits = 0; end
                        end else if (a > UNLOCK_THR) begin
                            m_mode = 1; m_hits = 0;
                        end
                        m_cnt = 0; m_net = 0;
                    end
                end
            end
            if (m_mode == 0) m_mode = 1;
        end
        x.pi = m_phase >> 8;
        x.lk = (m_mode == 2) ? 1 : 0;
        x.ia = m_int;
        x.dv = m_dv;
        x.dq = m_dout;
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic en_i, input logic v_i, input logic [3:0] d, input logic [3:0] e);
        @(negedge clk);
        en = en_i; smp_valid = v_i; data_smp = d; edge_smp = e;
        model_step(en_i, v_i, d, e);
    endtask

    // Monitor: compare registered outputs just after each active edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("pi_code", int'(pi_code), x.pi);
                chk("lock", int'(lock), x.lk);
                chk("int_acc", int'($signed(int_acc)), x.ia);
                chk("dout_valid", int'(dout_valid), x.dv);
                chk("dout", int'(dout), x.dq);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Words with prev_bit=1 and msb=1, so the next word again sees prev_bit=1
    localparam logic [3:0] W_DATA = 4'b1010;
    localparam logic [3:0] E_EARLY = 4'b0101;
    localparam logic [3:0] E_LATE = 4'b1010;

    initial begin
        logic [3:0] rd, re;
        logic rv, ren;
        model_reset();
        #1;
        chk("rst_pi_code", int'(pi_code), 0);
        chk("rst_lock", int'(lock), 0);
        chk("rst_int_acc", int'(int_acc), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        #21 rst_n = 1'b1;

        repeat (3) drive(1'b0, 1'b1, 4'h5, 4'h3);
        drive(1'b1, 1'b0, 4'h0, 4'h0);

        // Late pattern from prev_bit=0: first update wraps phase 0 -> 32704
        drive(1'b1, 1'b1, W_DATA, E_LATE);
        @(posedge clk); #2;
        chk("first_late_pi", int'(pi_code), 127);
        repeat (20) drive(1'b1, 1'b1, W_DATA, E_LATE);

        // No transitions, with gaps
        for (int i = 0; i < 30; i++) drive(1'b1, 1'($urandom_range(0, 3) != 0), 4'hF, 4'($urandom));
        // Balanced words: 2 early + 2 late
        for (int i = 0; i < 30; i++) drive(1'b1, 1'($urandom_range(0, 3) != 0), 4'b0101, 4'b0110);

        // Lock: restart windows, prime prev_bit=1, then alternate +1/-1 for four windows
        drive(1'b1, 1'b1, W_DATA, E_LATE);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 4 * LOCK_WIN; i++) begin
            drive(1'b1, 1'b1, W_DATA, (i % 2 == 0) ? E_EARLY : E_LATE);
            if (i == 4 * LOCK_WIN - 2) begin
                @(posedge clk); #2;
                chk("lock_before_256", int'(lock), 0);
            end
        end
        @(posedge clk); #2;
        chk("lock_after_256", int'(lock), 1);
        for (int i = 0; i < LOCK_WIN; i++) drive(1'b1, 1'b1, W_DATA, E_EARLY);
        @(posedge clk); #2;
        chk("unlock_after_window", int'(lock), 0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, W_DATA, (i % 2 == 0) ? E_LATE : E_EARLY);

        // Saturation run with idle cycles interleaved
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, 4'($urandom), 4'($urandom));
            drive(1'b1, 1'b1, W_DATA, E_EARLY);
        end
        @(posedge clk); #2;
`ifdef CDR_FREQ_PATH_EN
        chk("int_acc_saturated", int'($signed(int_acc)), INT_LIM);
`else
        chk("int_acc_tied_zero", int'($signed(int_acc)), 0);
`endif

        // Random stimulus with occasional enable drops
        for (int i = 0; i < 600; i++) begin
            rd = 4'($urandom); re = 4'($urandom);
            rv = 1'($urandom_range(0, 4) != 0);
            ren = 1'($urandom_range(0, 24) != 0);
            drive(ren, rv, rd, re);
        end
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, W_DATA, E_LATE);
        drain();

        // Asynchronous reset in mid-cycle
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_pi_code", int'(pi_code), 0);
        chk("async_int_acc", int'(int_acc), 0);
        chk("async_lock", int'(lock), 0);
        chk("async_dout_valid", int'(dout_valid), 0);
        en = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 4'($urandom), 4'($urandom));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
